// File: rtl/vga_frame_scheduler.sv
// VGA timing generator that also grants game logic one tear-free update window per vblank.
// Optional macro VGA_FRAME_CNT_EN adds a 16-bit frame_count output used as a scroll time base.
module vga_frame_scheduler #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_POL  = 0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        frame_start,
  output logic        vblank_start,
  input  logic        upd_req,
  output logic        upd_grant,
  output logic        overrun,
  input  logic        overrun_clr
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] HLast     = 10'(HTotal - 1);
  localparam logic [9:0] VLast     = 10'(VTotal - 1);
  localparam logic [9:0] HVis      = 10'(H_VISIBLE);
  localparam logic [9:0] VVis      = 10'(V_VISIBLE);
  localparam logic [9:0] HSyncBeg  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HSyncEnd  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VSyncBeg  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VSyncEnd  = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic       SyncLvl   = (SYNC_POL != 0);

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_OPEN,
    ST_GRANTED,
    ST_CLOSED
  } arbState_t;

  logic [9:0] posX_q, posY_q;
  logic [9:0] posX_d, posY_d;
  logic       startNext;
  logic       vblankNext;
  logic       lastLineStart;

  logic [9:0] x_q, y_q;
  logic       hsync_q, vsync_q, blank_q;
  logic       frameStart_q, vblankStart_q;
  logic       grant_q, overrun_q;
  arbState_t  state_q;

  // The position register leads the outputs by nothing after the first edge; it resets to the
  // last pixel of the frame so the first clock presents (0,0) with frame_start.
  always_comb begin
    posX_d = posX_q + 10'd1;
    posY_d = posY_q;
    if (posX_q == HLast) begin
      posX_d = 10'd0;
      posY_d = (posY_q == VLast) ? 10'd0 : posY_q + 10'd1;
    end
  end

  assign startNext     = (posX_d == 10'd0) && (posY_d == 10'd0);
  assign vblankNext    = (posX_d == 10'd0) && (posY_d == VVis);
  assign lastLineStart = (posX_q == 10'd0) && (posY_q == VLast);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      posX_q        <= HLast;
      posY_q        <= VLast;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      hsync_q       <= ~SyncLvl;
      vsync_q       <= ~SyncLvl;
      blank_q       <= 1'b1;
      frameStart_q  <= 1'b0;
      vblankStart_q <= 1'b0;
    end else begin
      posX_q        <= posX_d;
      posY_q        <= posY_d;
      x_q           <= posX_d;
      y_q           <= posY_d;
      hsync_q       <= (posX_d >= HSyncBeg && posX_d < HSyncEnd) ? SyncLvl : ~SyncLvl;
      vsync_q       <= (posY_d >= VSyncBeg && posY_d < VSyncEnd) ? SyncLvl : ~SyncLvl;
      blank_q       <= (posX_d >= HVis) || (posY_d >= VVis);
      frameStart_q  <= startNext;
      vblankStart_q <= vblankNext;
    end
  end

  // One grant per frame; the window is forcibly closed at the start of the last line so the
  // renderer always gets the final line to settle before the next frame.
  // A forced close is placed after the clear so a coincident clear cannot hide a new overrun.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_ACTIVE;
      grant_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (overrun_clr) begin
        overrun_q <= 1'b0;
      end
      if (startNext) begin
        state_q <= ST_ACTIVE;
        grant_q <= 1'b0;
      end else begin
        case (state_q)
          ST_ACTIVE: begin
            if (vblankNext) begin
              state_q <= ST_OPEN;
            end
          end
          ST_OPEN: begin
            if (lastLineStart) begin
              state_q <= ST_CLOSED;
            end else if (upd_req && (posY_q < VLast)) begin
              state_q <= ST_GRANTED;
              grant_q <= 1'b1;
            end
          end
          ST_GRANTED: begin
            if (!upd_req) begin
              state_q <= ST_CLOSED;
              grant_q <= 1'b0;
            end else if (lastLineStart) begin
              state_q   <= ST_CLOSED;
              grant_q   <= 1'b0;
              overrun_q <= 1'b1;
            end
          end
          default: begin
            state_q <= ST_CLOSED;
          end
        endcase
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frameCnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frameCnt_q <= 16'd0;
    end else if (startNext) begin
      frameCnt_q <= frameCnt_q + 16'd1;
    end
  end

  assign frame_count = frameCnt_q;
`endif

  assign x            = x_q;
  assign y            = y_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign blank        = blank_q;
  assign frame_start  = frameStart_q;
  assign vblank_start = vblankStart_q;
  assign upd_grant    = grant_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Scoreboard bench for vga_frame_scheduler on a shrunken 40x20 raster (800 cycles per frame).
// Expected event cycles are pushed with the stimulus; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_vga_frame_scheduler;

  localparam int HV = 20, HF = 4, HS = 6, HB = 10;
  localparam int VV = 10, VF = 3, VS = 2, VB = 5;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;

  localparam int EV_FS = 0, EV_VB = 1, EV_GUP = 2, EV_GDN = 3, EV_OUP = 4, EV_ODN = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       upd_req = 1'b0;
  logic       overrun_clr = 1'b0;
  logic       hsync, vsync, blank;
  logic [9:0] x, y;
  logic       frame_start, vblank_start, upd_grant, overrun;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_count;
`endif

  int compared = 0;
  int mismatched = 0;
  int cyc = -1;
  int evQ[6][$];

  always #5 clock = ~clock;

  vga_frame_scheduler #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .hsync(hsync),
    .vsync(vsync),
    .blank(blank),
    .x(x),
    .y(y),
    .frame_start(frame_start),
    .vblank_start(vblank_start),
    .upd_req(upd_req),
    .upd_grant(upd_grant),
    .overrun(overrun),
    .overrun_clr(overrun_clr)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_count(frame_count)
`endif
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  // An event with nothing queued is compared against -1 so it always registers as unexpected.
  task automatic popEvent(input int k, input string name);
    if (evQ[k].size() == 0) checkOutput(name, cyc, -1);
    else checkOutput(name, cyc, evQ[k].pop_front());
  endtask

  task automatic atCycle(input int n);
    do begin
      @(negedge clock);
      #1;
    end while (cyc < n);
  endtask

  task automatic applyStimulus(input int n, input logic req, input logic clr);
    atCycle(n);
    upd_req = req;
    overrun_clr = clr;
  endtask

  // Monitor: independent raster model plus event scoreboard, sampled on the falling edge.
  int   refX, refY, fsSeen;
  logic prevGrant, prevOv, expH, expV, expB;

  always @(negedge clock) begin
    if (reset) begin
      cyc = -1;
      refX = HT - 1;
      refY = VT - 1;
      fsSeen = 0;
      prevGrant = 1'b0;
      prevOv = 1'b0;
      checkOutput("resetState", int'({x, y, hsync, vsync, blank, frame_start, vblank_start, upd_grant, overrun}),
                  int'({10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
    end else begin
      cyc++;
      if (refX == HT - 1) begin
        refX = 0;
        refY = (refY == VT - 1) ? 0 : refY + 1;
      end else begin
        refX = refX + 1;
      end
      expH = !(refX >= HV + HF && refX < HV + HF + HS);
      expV = !(refY >= VV + VF && refY < VV + VF + VS);
      expB = (refX >= HV) || (refY >= VV);
      checkOutput("timing", int'({x, y, hsync, vsync, blank}),
                  int'({10'(refX), 10'(refY), expH, expV, expB}));
      if (frame_start) begin
        popEvent(EV_FS, "frameStart");
        fsSeen++;
`ifdef VGA_FRAME_CNT_EN
        checkOutput("frameCount", int'(frame_count), fsSeen);
`endif
      end
      if (vblank_start) popEvent(EV_VB, "vblankStart");
      if (upd_grant && !prevGrant) popEvent(EV_GUP, "grantRise");
      if (!upd_grant && prevGrant) popEvent(EV_GDN, "grantFall");
      if (overrun && !prevOv) popEvent(EV_OUP, "overrunRise");
      if (!overrun && prevOv) popEvent(EV_ODN, "overrunFall");
      prevGrant = upd_grant;
      prevOv = overrun;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 reset = 1'b1;
    for (int f = 0; f < 5; f++) begin
      evQ[EV_FS].push_back(f * FT);
      evQ[EV_VB].push_back(f * FT + VV * HT);
    end
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;

    // Request raised mid-frame is held until the cycle after vblank_start, then released.
    evQ[EV_GUP].push_back(401);
    applyStimulus(80, 1'b1, 1'b0);
    evQ[EV_GDN].push_back(521);
    applyStimulus(520, 1'b0, 1'b0);

    // Re-raise after release: waits for next frame, then overstays and is revoked.
    evQ[EV_GUP].push_back(1201);
    evQ[EV_GDN].push_back(1561);
    evQ[EV_OUP].push_back(1561);
    applyStimulus(600, 1'b1, 1'b0);
    applyStimulus(1600, 1'b0, 1'b0);
    evQ[EV_GUP].push_back(2001);
    applyStimulus(1650, 1'b1, 1'b0);
    checkOutput("overrunSticky", int'(overrun), 1);
    evQ[EV_ODN].push_back(1701);
    applyStimulus(1700, 1'b1, 1'b1);
    applyStimulus(1701, 1'b1, 1'b0);

    // Clear coincident with a new forced revoke: the new overrun must survive.
    evQ[EV_GDN].push_back(2361);
    evQ[EV_OUP].push_back(2361);
    applyStimulus(2360, 1'b1, 1'b1);
    applyStimulus(2361, 1'b1, 1'b0);
    applyStimulus(2365, 1'b0, 1'b0);
    evQ[EV_ODN].push_back(2371);
    applyStimulus(2370, 1'b0, 1'b1);
    applyStimulus(2371, 1'b0, 1'b0);

    // Request arriving on the last line is not granted there; it waits for the next vblank.
    evQ[EV_GUP].push_back(3601);
    applyStimulus(3160, 1'b1, 1'b0);

    // Reset during a grant drops outputs without a clock edge.
    atCycle(3805);
    checkOutput("grantBeforeReset", int'(upd_grant), 1);
    reset = 1'b1;
    #1;
    checkOutput("asyncReset", int'({x, y, upd_grant}), 0);
    repeat (2) @(negedge clock);
    evQ[EV_FS].push_back(0);
    evQ[EV_VB].push_back(VV * HT);
    evQ[EV_GUP].push_back(401);
    #2 reset = 1'b0;
    evQ[EV_GDN].push_back(451);
    applyStimulus(450, 1'b0, 1'b0);
    atCycle(520);

    for (int k = 0; k < 6; k++) begin
      while (evQ[k].size() > 0) checkOutput("missingEvent", evQ[k].pop_front(), -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
